// File: rtl/prio_enc_scan_hex_if.sv
// prio_enc_scan_hex_if: request/readout bundle for the priority encoder.
// Ports (signals):
//   x     request vector, bit i set = request i active
//   mode  0 = priority, 1 = scan
//   idx   encoded index (registered)
//   valid 1 when x was nonzero at the last edge (registered)
//   cnt   population count of x (registered)
//   hex0  seven-seg for idx[3:0]
//   hex1  seven-seg for the index bits above bit 3
//   hexv  seven-seg showing valid as 1/0
// master drives x/mode and reads the results; slave is the encoder.
interface prio_enc_scan_hex_if #(
  parameter int N     = 16,
  parameter int IDX_W = 4
);
  logic [N-1:0]     x;
  logic             mode;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [IDX_W:0]   cnt;
  logic [6:0]       hex0;
  logic [6:0]       hex1;
  logic [6:0]       hexv;

  modport master (
    output x, mode,
    input  idx, valid, cnt, hex0, hex1, hexv
  );

  modport slave (
    input  x, mode,
    output idx, valid, cnt, hex0, hex1, hexv
  );
endinterface

// File: rtl/prio_enc_scan_hex.sv
// prio_enc_scan_hex: clocked priority encoder with a scan mode and
// seven-segment readout of the encoded index.
// Ports:
//   clk   system clock, rising edge
//   clrn  asynchronous active-low reset
//   bus   prio_enc_scan_hex_if.slave (x, mode in; idx, valid, cnt, hex0,
//         hex1, hexv out)
// Priority mode reports the highest set bit of x. Scan mode walks every set
// bit from low to high, holding each for DWELL cycles, then wraps.
module prio_enc_scan_hex #(
  parameter int N     = 16,
  parameter int IDX_W = 4,
  parameter int DWELL = 50000000
) (
  input logic                clk,
  input logic                clrn,
  prio_enc_scan_hex_if.slave bus
);

  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CNT_W   = IDX_W + 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRIO = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         lo_nib;
  logic [3:0]         hi_nib;

  function automatic logic [IDX_W-1:0] highest_bit(input logic [N-1:0] v);
    highest_bit = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) highest_bit = IDX_W'(i);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_bit(input logic [N-1:0] v);
    lowest_bit = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) lowest_bit = IDX_W'(i);
  endfunction

  // Lowest set bit strictly above cur; falls back to the lowest set bit
  // overall so the walk wraps around.
  function automatic logic [IDX_W-1:0] next_bit(input logic [N-1:0] v,
                                                input logic [IDX_W-1:0] cur);
    next_bit = lowest_bit(v);
    for (int i = N - 1; i >= 0; i--)
      if (v[i] && (i > int'(cur))) next_bit = IDX_W'(i);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    popcount = '0;
    for (int i = 0; i < N; i++)
      popcount = popcount + CNT_W'(v[i]);
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // x == 0 always wins and parks the encoder in IDLE. Otherwise any entry
  // into SCAN starts at the lowest set bit with a fresh dwell count, and a
  // scan step happens either on dwell expiry or when the bit being shown
  // disappears; both together still give only one step.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      cnt_q <= popcount(bus.x);
      if (bus.x == '0) begin
        state   <= IDLE;
        idx_q   <= '0;
        valid_q <= 1'b0;
        dwell_q <= '0;
      end else begin
        valid_q <= 1'b1;
        case (state)
          SCAN: begin
            if (!bus.mode) begin
              state   <= PRIO;
              idx_q   <= highest_bit(bus.x);
              dwell_q <= '0;
            end else if (!bus.x[idx_q] || (dwell_q == DWELL_LAST)) begin
              idx_q   <= next_bit(bus.x, idx_q);
              dwell_q <= '0;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          default: begin
            dwell_q <= '0;
            if (bus.mode) begin
              state <= SCAN;
              idx_q <= lowest_bit(bus.x);
            end else begin
              state <= PRIO;
              idx_q <= highest_bit(bus.x);
            end
          end
        endcase
      end
    end
  end

  // idx is already zero whenever valid is low, so blanking to 0 here only
  // makes that guarantee explicit at the display.
  assign lo_nib = valid_q ? 4'(idx_q) : 4'd0;
  assign hi_nib = valid_q ? 4'(idx_q >> 4) : 4'd0;

  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.cnt   = cnt_q;
  assign bus.hex0  = seg7(lo_nib);
  assign bus.hex1  = seg7(hi_nib);
  assign bus.hexv  = seg7({3'b000, valid_q});

endmodule

// File: tb/tb_prio_enc_scan_hex.sv
// tb_prio_enc_scan_hex: directed bench for prio_enc_scan_hex.
// Drives a 16-bit instance (DWELL=3) and a 32-bit instance (IDX_W=5) from a
// shared clock and reset, with hand-computed expected values.
module tb_prio_enc_scan_hex;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SF = 7'b0001110;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;

  prio_enc_scan_hex_if #(.N(16), .IDX_W(4)) b16 ();
  prio_enc_scan_hex_if #(.N(32), .IDX_W(5)) b32 ();

  prio_enc_scan_hex #(.N(16), .IDX_W(4), .DWELL(3)) dut16 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (b16.slave)
  );

  prio_enc_scan_hex #(.N(32), .IDX_W(5), .DWELL(3)) dut32 (
    .clk  (clk),
    .clrn (clrn),
    .bus  (b32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] x, input logic mode);
    b16.x    = x;
    b16.mode = mode;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clrn   = 1'b0;
    apply_stimulus(16'hFFFF, 1'b0);
    b32.x    = 32'h0;
    b32.mode = 1'b0;

    // Reset held with all requests active
    repeat (3) tick();
    check_output("rst_idx",   32'(b16.idx),   32'd0);
    check_output("rst_valid", 32'(b16.valid), 32'd0);
    check_output("rst_cnt",   32'(b16.cnt),   32'd0);
    check_output("rst_hexv",  32'(b16.hexv),  32'(S0));
    check_output("rst_hex0",  32'(b16.hex0),  32'(S0));

    clrn = 1'b1;
    tick();
    check_output("rel_idx",  32'(b16.idx),  32'd15);
    check_output("rel_cnt",  32'(b16.cnt),  32'd16);
    check_output("rel_hex0", 32'(b16.hex0), 32'(SF));
    check_output("rel_hexv", 32'(b16.hexv), 32'(S1));

    // Priority sweep
    apply_stimulus(16'h0000, 1'b0);
    tick();
    check_output("p0_valid", 32'(b16.valid), 32'd0);
    check_output("p0_idx",   32'(b16.idx),   32'd0);
    apply_stimulus(16'h0001, 1'b0);
    tick();
    check_output("p1_idx",   32'(b16.idx),   32'd0);
    check_output("p1_valid", 32'(b16.valid), 32'd1);
    apply_stimulus(16'h0120, 1'b0);
    tick();
    check_output("p120_idx",  32'(b16.idx),  32'd8);
    check_output("p120_hex0", 32'(b16.hex0), 32'(S8));
    apply_stimulus(16'h0B00, 1'b0);
    tick();
    check_output("pB00_idx",  32'(b16.idx),  32'd11);
    check_output("pB00_hex0", 32'(b16.hex0), 32'(SB));
    check_output("pB00_cnt",  32'(b16.cnt),  32'd3);
    check_output("pB00_hex1", 32'(b16.hex1), 32'(S0));

    // Wide instance: index above 15 uses hex1
    b32.x = 32'h8000_0000;
    tick();
    check_output("w_idx",  32'(b32.idx),  32'd31);
    check_output("w_hex0", 32'(b32.hex0), 32'(SF));
    check_output("w_hex1", 32'(b32.hex1), 32'(S1));
    check_output("w_cnt",  32'(b32.cnt),  32'd1);
    b32.x = 32'h0;
    tick();
    check_output("w0_idx",   32'(b32.idx),   32'd0);
    check_output("w0_valid", 32'(b32.valid), 32'd0);
    check_output("w0_hex0",  32'(b32.hex0),  32'(S0));
    check_output("w0_hex1",  32'(b32.hex1),  32'(S0));
    check_output("w0_hexv",  32'(b32.hexv),  32'(S0));

    // Scan walk with wrap: 0,0,0,4,4,4,7,7,7,0
    apply_stimulus(16'h0091, 1'b1);
    begin
      logic [3:0] seq [10] = '{4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4,
                               4'd7, 4'd7, 4'd7, 4'd0};
      for (int i = 0; i < 10; i++) begin
        tick();
        check_output($sformatf("scan_idx%0d", i), 32'(b16.idx), 32'(seq[i]));
        check_output($sformatf("scan_v%0d", i), 32'(b16.valid), 32'd1);
      end
    end

    // Mode switch mid-scan at idx 0
    apply_stimulus(16'h0091, 1'b0);
    tick();
    check_output("ms_prio", 32'(b16.idx), 32'd7);
    apply_stimulus(16'h0091, 1'b1);
    tick();
    check_output("ms_scan0", 32'(b16.idx), 32'd0);
    tick();
    check_output("ms_scan1", 32'(b16.idx), 32'd0);
    tick();
    check_output("ms_scan2", 32'(b16.idx), 32'd0);
    tick();
    check_output("ms_scan3", 32'(b16.idx), 32'd4);

    // Current bit cleared at dwell 1 while showing 4
    tick();
    check_output("cc_pre", 32'(b16.idx), 32'd4);
    apply_stimulus(16'h0081, 1'b1);
    tick();
    check_output("cc_jump", 32'(b16.idx), 32'd7);
    tick();
    check_output("cc_hold1", 32'(b16.idx), 32'd7);
    tick();
    check_output("cc_hold2", 32'(b16.idx), 32'd7);
    tick();
    check_output("cc_wrap", 32'(b16.idx), 32'd0);

    // Expiry and clear of bit 0 together: one step to bit 1, not bit 4
    tick();
    tick();
    apply_stimulus(16'h0092, 1'b1);
    tick();
    check_output("both_idx", 32'(b16.idx), 32'd1);
    check_output("both_cnt", 32'(b16.cnt), 32'd3);

    // Request vector empties during scan
    apply_stimulus(16'h0000, 1'b1);
    tick();
    check_output("idle_valid", 32'(b16.valid), 32'd0);
    check_output("idle_idx",   32'(b16.idx),   32'd0);
    check_output("idle_hex0",  32'(b16.hex0),  32'(S0));

    // Reset mid-scan while showing 4, then fresh scan entry
    apply_stimulus(16'h0091, 1'b1);
    repeat (4) tick();
    check_output("mr_pre", 32'(b16.idx), 32'd4);
    clrn = 1'b0;
    #1;
    check_output("mr_idx",   32'(b16.idx),   32'd0);
    check_output("mr_valid", 32'(b16.valid), 32'd0);
    check_output("mr_cnt",   32'(b16.cnt),   32'd0);
    tick();
    clrn = 1'b1;
    tick();
    check_output("mr_re_idx",   32'(b16.idx),   32'd0);
    check_output("mr_re_valid", 32'(b16.valid), 32'd1);
    tick();
    tick();
    tick();
    check_output("mr_re_step", 32'(b16.idx), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
